// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL lock sequencer.
package pll_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_seq_state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_GLITCH_CYCLES = 4;
    localparam int DEF_COUNT_W       = 8;

    // Counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Turns the PLL lock flag into a filtered, two-stage sequenced core reset with loss tracking.
module pll_lock_sequencer
    import pll_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
    parameter int COUNT_W       = DEF_COUNT_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               locked,
    input  logic               clear_status,
    output logic               reset_out_n,
    output logic               ready,
    output logic               lock_lost,
    output logic [COUNT_W-1:0] loss_count,
    output logic [1:0]         state
);

    localparam int SCW = cnt_width(STABLE_CYCLES);
    localparam int HCW = cnt_width(HOLD_CYCLES);
    localparam int GCW = cnt_width(GLITCH_CYCLES);

    logic locked_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (locked),
        .q_o     (locked_s)
    );

    pll_seq_state_t     state_q, state_d;
    logic [SCW-1:0]     stable_cnt_q, stable_cnt_d;
    logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [GCW-1:0]     low_cnt_q, low_cnt_d;
    logic               lock_lost_q, lock_lost_d;
    logic [COUNT_W-1:0] loss_count_q, loss_count_d;
    logic               reset_out_n_q, ready_q;
    logic               loss_evt;

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        low_cnt_d    = low_cnt_q;
        loss_evt     = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d      = STABLE;
                    stable_cnt_d = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (stable_cnt_q == SCW'(STABLE_CYCLES - 1)) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                    low_cnt_d  = '0;
                end else begin
                    stable_cnt_d = stable_cnt_q + SCW'(1);
                end
            end
            HOLD: begin
                if (hold_cnt_q == HCW'(HOLD_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: ;
        endcase

        // Glitch filter: the edge that would take the low run to GLITCH_CYCLES is the loss.
        if (state_q == HOLD || state_q == RUN) begin
            if (locked_s) begin
                low_cnt_d = '0;
            end else if (low_cnt_q == GCW'(GLITCH_CYCLES - 1)) begin
                loss_evt  = 1'b1;
                state_d   = WAIT_LOCK;
                low_cnt_d = '0;
            end else begin
                low_cnt_d = low_cnt_q + GCW'(1);
            end
        end
    end

    always_comb begin
        lock_lost_d  = lock_lost_q;
        loss_count_d = loss_count_q;
        if (loss_evt) begin
            lock_lost_d  = 1'b1;
            loss_count_d = clear_status    ? COUNT_W'(1)  :
                           (&loss_count_q) ? loss_count_q :
                                             loss_count_q + COUNT_W'(1);
        end else if (clear_status) begin
            lock_lost_d  = 1'b0;
            loss_count_d = '0;
        end
    end

    // Outputs decode the next state so they change on the same edge as state_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT_LOCK;
            stable_cnt_q  <= '0;
            hold_cnt_q    <= '0;
            low_cnt_q     <= '0;
            lock_lost_q   <= 1'b0;
            loss_count_q  <= '0;
            reset_out_n_q <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            stable_cnt_q  <= stable_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            low_cnt_q     <= low_cnt_d;
            lock_lost_q   <= lock_lost_d;
            loss_count_q  <= loss_count_d;
            reset_out_n_q <= (state_d == HOLD) || (state_d == RUN);
            ready_q       <= (state_d == RUN);
        end
    end

    assign reset_out_n = reset_out_n_q;
    assign ready       = ready_q;
    assign lock_lost   = lock_lost_q;
    assign loss_count  = loss_count_q;
    assign state       = state_q;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Consumes the `locked` output of the iCE40 PLL wrapper and turns it into a clean, synchronized, sequenced reset for the 200 MHz core domain. It runs on the PLL output clock, waits for a stable lock, releases reset in two stages, filters short lock glitches, and records lock-loss events for the STM32H7-facing status registers.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on the `locked` synchronizer; legal range 2–4.
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before reset release; minimum 1.
- `HOLD_CYCLES`, 16: cycles between `reset_out_n` deassertion and `ready` assertion; minimum 1.
- `GLITCH_CYCLES`, 4: consecutive unlocked cycles in HOLD or RUN that count as a real loss; minimum 1.
- `COUNT_W`, 8: width of `loss_count`.

Ports:
- `clock`  in  1  PLL output clock (200 MHz).
- `reset_n`  in  1  Reset; asynchronous assert, active-low.
- `locked`  in  1  PLL lock; asynchronous to `clock`.
- `clear_status`  in  1  Single-cycle pulse; clears `lock_lost` and `loss_count`.
- `reset_out_n`  out  1  Core-domain reset, active-low; registered.
- `ready`  out  1  Core domain released and settled; registered.
- `lock_lost`  out  1  Sticky flag: at least one filtered loss since the last clear.
- `loss_count`  out  COUNT_W  Saturating count of filtered losses.
- `state`  out  2  Current FSM state, for debug/status.

## Operation
- `locked` passes through a SYNC_STAGES flop chain → `locked_s`. No other logic samples `locked`.
- FSM states, encoded in `state`: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
- WAIT_LOCK: when `locked_s`=1, go to STABLE and clear the cycle counter.
- STABLE: when `locked_s`=1, the counter increments. When the counter reaches STABLE_CYCLES-1 with `locked_s`=1, go to HOLD. Any `locked_s`=0 returns the FSM to WAIT_LOCK. This is not a loss event.
- HOLD: the counter counts to HOLD_CYCLES-1, then the FSM goes to RUN.
- RUN: idle.
- Glitch filter, active in HOLD and RUN:
  - The low counter increments on each `locked_s`=0 cycle and clears on any `locked_s`=1 cycle.
  - When it reaches GLITCH_CYCLES, the FSM goes to WAIT_LOCK, `lock_lost` is set, and `loss_count` increments, saturating at all-ones.
  - Shorter low runs have no effect. The HOLD counter keeps running during a sub-threshold glitch.
- Outputs are registered and decoded from the next state:
  - `reset_out_n`=1 iff the state is HOLD or RUN.
  - `ready`=1 iff the state is RUN.
- `clear_status` in the same cycle as a loss event: the loss wins, so `lock_lost`=1 and `loss_count`=1.
- Reset values:
  - `state`=WAIT_LOCK.
  - `reset_out_n`=0, `ready`=0, `lock_lost`=0, `loss_count`=0.
  - Synchronizer flops = 0; all counters = 0.
- Asserting `reset_n` mid-operation immediately forces all of the above, including an asynchronous drop of `reset_out_n`.

## Timing
- Take edge 0 as the first edge at which `locked_s`=1 in WAIT_LOCK. `locked` must be high ≥ SYNC_STAGES edges earlier.
- STABLE is entered at edge 1.
- `reset_out_n` rises after edge STABLE_CYCLES+1.
- `ready` rises after edge STABLE_CYCLES+HOLD_CYCLES+1.
- Loss response: `reset_out_n` and `ready` fall on the edge where the low counter reaches GLITCH_CYCLES. That is GLITCH_CYCLES edges after the first `locked_s`=0, plus SYNC_STAGES from the `locked` pin.
- `lock_lost` and `loss_count` update on that same edge.
- `clear_status` takes effect on the next edge.
- Counter widths are clog2 of the respective parameter. No wrap occurs, because each counter's terminal value forces a state change.

## Structure
- Shared package `pll_pkg`:
  - State enum `pll_seq_state_t` (2 bits).
  - Default parameter constants.
- Sub-module `sync_ff`:
  - Parameter STAGES, 1-bit, async active-low reset to 0.
  - Reused for every other async input in the design.

## Test plan
- Lock-up sequence: reset, then raise `locked` with defaults → `reset_out_n` rises exactly 1025 cycles after `locked_s` first rises, `ready` exactly 16 cycles later, `state`=3, `lock_lost`=0.
- Drop during STABLE: drop `locked` for 1 cycle after 500 stable cycles → FSM in WAIT_LOCK, full 1024-cycle count restarts, `loss_count` stays 0.
- Glitch rejection: in RUN, drop `locked` for 3 cycles (GLITCH_CYCLES=4) → `ready` stays 1, `loss_count` stays 0.
- Real loss: in RUN, drop `locked` for 4 cycles → `reset_out_n`=0 and `ready`=0 on the 4th low `locked_s` edge, `lock_lost`=1, `loss_count`=1. Relock → full sequence repeats.
- Counter saturation and clear: COUNT_W=2 with 5 losses → `loss_count`=3. `clear_status` coincident with the 6th loss → `lock_lost`=1, `loss_count`=1. A clear alone afterwards → both 0.
- Async reset mid-HOLD: assert `reset_n` between edges → `reset_out_n`=0 before the next edge, `state`=0, all counters and flags cleared.
